// File: rtl/spatial_bundler.sv
// -----------------------------------------------------------------------------
// spatial_bundler
//
// Spatial encoder for hyperdimensional sensor fusion. Each accepted channel
// hypervector is bound (XOR) to the projection vector chosen by its quantised
// feature. The result then casts one vote per bit. After CHANNELS channels,
// the bitwise majority hypervector is offered downstream over a valid/ready
// port.
//
// Optional feature (compile-time macro TIEBREAK_XOR_EN):
//   The bound vector of the second accepted channel is stored. On the last
//   channel, each bit receives one extra vote, equal to bound_last ^ stored.
//   The total vote count is then CHANNELS+1, so an even CHANNELS can no longer
//   tie. Without the macro, ties resolve to 0.
//
// Ports:
//   Clk_CI       clock
//   Reset_RI     synchronous reset, active-high
//   Clear_SI     abort the current bundle and return to IDLE
//   ChValid_SI   channel input valid
//   ChReady_SO   channel input ready (registered)
//   ChHv_DI      channel item-memory hypervector [DIM]
//   Feature_DI   quantised feature: 1=pos, 2=neg, 0/3=none
//   ProjPos_DI   positive projection vector [DIM]
//   ProjNeg_DI   negative projection vector [DIM]
//   OutValid_SO  bundled hypervector valid (registered)
//   OutReady_SI  downstream ready
//   HvOut_DO     bundled hypervector (registered) [DIM]
//   ChCount_DO   channels accepted in the current bundle [CNT_W]
// -----------------------------------------------------------------------------
module spatial_bundler #(
   parameter int DIM      = 2000,
   parameter int CHANNELS = 64,
   parameter int CNT_W    = $clog2(CHANNELS + 2)
) (
   input  logic             Clk_CI,
   input  logic             Reset_RI,
   input  logic             Clear_SI,
   input  logic             ChValid_SI,
   output logic             ChReady_SO,
   input  logic [DIM-1:0]   ChHv_DI,
   input  logic [1:0]       Feature_DI,
   input  logic [DIM-1:0]   ProjPos_DI,
   input  logic [DIM-1:0]   ProjNeg_DI,
   output logic             OutValid_SO,
   input  logic             OutReady_SI,
   output logic [DIM-1:0]   HvOut_DO,
   output logic [CNT_W-1:0] ChCount_DO
);

`ifdef TIEBREAK_XOR_EN
   localparam int VOTES = CHANNELS + 1;
`else
   localparam int VOTES = CHANNELS;
`endif

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHANNELS - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      EMIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] acc [DIM];
   logic [DIM-1:0]   bound;
   logic [DIM-1:0]   extra;
   logic [DIM-1:0]   hv_next;
   logic             accept;

`ifdef TIEBREAK_XOR_EN
   logic [DIM-1:0]   second;
`endif

   assign accept = ChValid_SI && ChReady_SO;

   // Binding: feature selects which projection the channel vector is XORed
   // with. An unused feature still produces a (zero) vote vector.
   always_comb begin
      bound = '0;
      case (Feature_DI)
         2'd1:    bound = ChHv_DI ^ ProjPos_DI;
         2'd2:    bound = ChHv_DI ^ ProjNeg_DI;
         default: bound = '0;
      endcase
   end

   // Extra tie-break vote, only meaningful on the last channel of a bundle.
`ifdef TIEBREAK_XOR_EN
   assign extra = bound ^ second;
`else
   assign extra = '0;
`endif

   // Majority of the finished bundle. This includes the vote of the channel
   // being accepted right now, so the result can be registered on the same
   // edge as the last accept.
   always_comb begin
      hv_next = '0;
      for (int b = 0; b < DIM; b++) begin
         int total;
         total = int'(acc[b]) + int'(bound[b]) + int'(extra[b]);
         hv_next[b] = ((2 * total) > VOTES);
      end
   end

   // Single FSM. Priority: reset, then clear, then normal operation.
   // The first accept of a bundle loads the accumulators instead of adding
   // to them, so an aborted bundle leaves no stale votes behind.
   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         state       <= IDLE;
         ChReady_SO  <= 1'b1;
         OutValid_SO <= 1'b0;
         HvOut_DO    <= '0;
         ChCount_DO  <= '0;
         for (int b = 0; b < DIM; b++) acc[b] <= '0;
`ifdef TIEBREAK_XOR_EN
         second      <= '0;
`endif
      end else if (Clear_SI) begin
         state       <= IDLE;
         ChReady_SO  <= 1'b1;
         OutValid_SO <= 1'b0;
         ChCount_DO  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  for (int b = 0; b < DIM; b++)
                     acc[b] <= {{(CNT_W-1){1'b0}}, bound[b]};
                  ChCount_DO <= ONE_CNT;
                  state      <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  for (int b = 0; b < DIM; b++)
                     acc[b] <= acc[b] + {{(CNT_W-1){1'b0}}, bound[b]};
                  ChCount_DO <= ChCount_DO + ONE_CNT;
`ifdef TIEBREAK_XOR_EN
                  if (ChCount_DO == ONE_CNT) second <= bound;
`endif
                  if (ChCount_DO == LAST_CNT) begin
                     HvOut_DO    <= hv_next;
                     OutValid_SO <= 1'b1;
                     ChReady_SO  <= 1'b0;
                     state       <= EMIT;
                  end
               end
            end
            EMIT: begin
               if (OutReady_SI) begin
                  OutValid_SO <= 1'b0;
                  ChReady_SO  <= 1'b1;
                  ChCount_DO  <= '0;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               ChReady_SO  <= 1'b1;
               OutValid_SO <= 1'b0;
               ChCount_DO  <= '0;
            end
         endcase
      end
   end

endmodule
